// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a 2-entry skid buffer, valid/ready handshake, stall and flush.
// Latency: 1 cycle from acceptance to out_*; sustains 1 entry/cycle. Backpressure: in_ready drops only when both entries are full or stalled.
// Bubbles (invalid/flushed entries) always carry NOP_CTRL so no stale control bits can leak downstream.
module pipe_skid_stage #(
    parameter int              DW       = 64,
    parameter int              CW       = 8,
    parameter logic [CW-1:0]   NOP_CTRL = '0
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [CW-1:0] in_ctrl,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] out_ctrl,
    input  logic          stall,
    input  logic          flush,
    output logic [1:0]    occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] main_data_q, main_data_d;
    logic [CW-1:0] main_ctrl_q, main_ctrl_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic [CW-1:0] skid_ctrl_q, skid_ctrl_d;

    logic main_vld;
    logic push;
    logic pop;

    assign main_vld  = (state_q != EMPTY);
    // nRST gates in_ready so upstream never sees a grant while the stage is held in reset.
    assign in_ready  = nRST && !stall && (state_q != TWO);
    assign out_valid = !stall && main_vld;
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : NOP_CTRL;
    assign occupancy = state_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            state_d     = EMPTY;
            main_data_d = '0;
            main_ctrl_d = NOP_CTRL;
            skid_data_d = '0;
            skid_ctrl_d = NOP_CTRL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (push) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = TWO;
                    end else if (pop) begin
                        main_data_d = '0;
                        main_ctrl_d = NOP_CTRL;
                        state_d     = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can move the skid entry forward.
                    if (pop) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_data_d = '0;
                        skid_ctrl_d = NOP_CTRL;
                        state_d     = ONE;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_data_d = '0;
                    main_ctrl_d = NOP_CTRL;
                    skid_data_d = '0;
                    skid_ctrl_d = NOP_CTRL;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= NOP_CTRL;
            skid_data_q <= '0;
            skid_ctrl_q <= NOP_CTRL;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed table, hand-written corner sequences and random traffic vs a queue model.
module tb_pipe_skid_stage;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          CLK;
    logic          nRST;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;
    logic          stall;
    logic          flush;

    logic          in_ready,  b_in_ready;
    logic          out_valid, b_out_valid;
    logic [DW-1:0] out_data,  b_out_data;
    logic [CW-1:0] out_ctrl,  b_out_ctrl;
    logic [1:0]    occupancy, b_occupancy;

    pipe_skid_stage #(.DW(DW), .CW(CW)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall(stall), .flush(flush), .occupancy(occupancy)
    );

    pipe_skid_stage #(.DW(DW), .CW(CW), .NOP_CTRL(8'h80)) dut_nop80 (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .stall(stall), .flush(flush), .occupancy(b_occupancy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare both DUTs against the queue model mid-cycle, then advance one clock.
    task automatic cycle();
        logic          m_ov, m_ir;
        logic [DW-1:0] m_d;
        logic [CW-1:0] m_c;
        ent_t          e;
        #1;
        if (!nRST) q.delete();
        m_ov = !stall && (q.size() > 0);
        m_ir = nRST && !stall && (q.size() < 2);
        m_d  = (q.size() > 0) ? q[0].d : '0;
        m_c  = m_ov ? q[0].c : 8'h00;
        chk("out_valid", out_valid, m_ov);
        chk("in_ready",  in_ready,  m_ir);
        chk("out_data",  out_data,  m_d);
        chk("out_ctrl",  out_ctrl,  m_c);
        chk("occupancy", occupancy, q.size());
        chk("nop80_out_ctrl", b_out_ctrl, m_ov ? q[0].c : 8'h80);
        @(posedge CLK);
        if (nRST) begin
            if (flush) begin
                q.delete();
            end else if (!stall) begin
                if (m_ov && out_ready) void'(q.pop_front());
                if (in_valid && m_ir) begin
                    e.d = in_data;
                    e.c = in_ctrl;
                    q.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ord, input logic st, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ord;
        stall     = st;
        flush     = fl;
    endtask

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ord;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [CW-1:0] e_oc;
        logic          e_ir;
        logic [1:0]    e_occ;
    } vec_t;

    vec_t tbl[7];

    initial begin
        // Backpressure then drain: A,B accepted, C held off until a slot frees.
        tbl[0] = '{1'b1, 16'h000A, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 2'd0};
        tbl[1] = '{1'b1, 16'h000B, 1'b0, 1'b1, 16'h000A, 8'h0A, 1'b1, 2'd1};
        tbl[2] = '{1'b1, 16'h000C, 1'b0, 1'b1, 16'h000A, 8'h0A, 1'b0, 2'd2};
        tbl[3] = '{1'b1, 16'h000C, 1'b1, 1'b1, 16'h000A, 8'h0A, 1'b0, 2'd2};
        tbl[4] = '{1'b1, 16'h000C, 1'b1, 1'b1, 16'h000B, 8'h0B, 1'b1, 2'd1};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C, 8'h0C, 1'b1, 2'd1};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 2'd0};

        // Reset with an offer pending.
        nRST = 1'b0;
        drive(1'b1, 16'hDEAD, 8'hAD, 1'b0, 1'b0, 1'b0);
        cycle();
        cycle();
        nRST = 1'b1;
        cycle();
        drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("post_reset_first_out", out_data, 16'hDEAD);
        cycle();
        cycle();

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DW'(i), CW'(i), 1'b1, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        cycle();
        cycle();

        // Table-driven backpressure sequence.
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].d[7:0], tbl[i].ord, 1'b0, 1'b0);
            #1;
            chk("tbl_out_valid", out_valid, tbl[i].e_ov);
            chk("tbl_out_data",  out_data,  tbl[i].e_od);
            chk("tbl_out_ctrl",  out_ctrl,  tbl[i].e_oc);
            chk("tbl_in_ready",  in_ready,  tbl[i].e_ir);
            chk("tbl_occupancy", occupancy, tbl[i].e_occ);
            cycle();
        end

        // Stall with both entries full.
        drive(1'b1, 16'h000A, 8'hFF, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 16'h000B, 8'hFF, 1'b0, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0077, 8'h77, 1'b1, 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("stall_release_head", out_data, 16'h000A);
        cycle();
        chk("stall_release_next", out_data, 16'h000B);
        cycle();

        // Flush overriding stall and an offered entry.
        drive(1'b1, 16'h00A1, 8'hFF, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 16'h00B2, 8'hFF, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 16'h00EE, 8'hFF, 1'b1, 1'b1, 1'b1);
        cycle();
        drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("flush_occupancy", occupancy, 2'd0);
        chk("flush_out_ctrl", out_ctrl, 8'h00);
        chk("flush_nop80_ctrl", b_out_ctrl, 8'h80);
        for (int i = 0; i < 3; i++) cycle();

        // Asynchronous reset with entries held.
        drive(1'b1, 16'h0033, 8'h33, 1'b0, 1'b0, 1'b0);
        cycle();
        cycle();
        #2;
        nRST = 1'b0;
        #1;
        chk("async_reset_occupancy", occupancy, 2'd0);
        chk("async_reset_nop80_ctrl", b_out_ctrl, 8'h80);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        q.delete();
        cycle();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), DW'($urandom), CW'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 39) == 0));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised pipeline-stage register, the successor to the fixed-field latch-on-enable stage registers between processor stages.
- Carries an arbitrary payload plus a control field with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under backpressure.
- Supports stall (hold) and flush (bubble insert); control bits are forced to a programmable NOP pattern whenever an entry is invalid or flushed.

Parameters:
DW, 64, payload width in bits (operands, instr, port values)
CW, 8, control field width (WEN, DRE, DWE, HALT, MemToReg, ...)
NOP_CTRL, {CW{1'b0}}, control pattern presented/stored for bubbles

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept this cycle
in_data  in  DW  upstream payload
in_ctrl  in  CW  upstream control bits
out_valid  out  1  head entry valid to downstream
out_ready  in  1  downstream accepts head this cycle
out_data  out  DW  head payload
out_ctrl  out  CW  head control; NOP_CTRL when out_valid=0
stall  in  1  freeze stage: no accept, no present, state held
flush  in  1  synchronous squash of all held entries
occupancy  out  2  entries held (0,1,2)

Behaviour:
- Storage: main entry (head) and skid entry, each {valid, data, ctrl}. FSM states: EMPTY (occ 0), ONE (main valid), TWO (main+skid valid).
- Async reset (nRST=0): state EMPTY, both valids 0, data 0, ctrl NOP_CTRL. Outputs during/after reset: out_valid=0, out_data=0, out_ctrl=NOP_CTRL, occupancy=0, in_ready=0 while nRST=0, in_ready=1 from first cycle after release (if stall=0). Reset mid-transfer discards everything.
- Combinational: in_ready = !stall && state!=TWO; out_valid = !stall && main.valid; out_ctrl = out_valid ? main.ctrl : NOP_CTRL; out_data = main.data (0 when empty); push = in_valid&&in_ready; pop = out_valid&&out_ready.
- Latency: accepted entry appears on out_* the cycle after acceptance; push+pop every cycle sustains 1 entry/cycle.
- Transitions on posedge CLK (flush=0, stall=0):
  - EMPTY: push -> main<=in, ONE; else stay.
  - ONE: push&pop -> main<=in, ONE; push only -> skid<=in, TWO; pop only -> main cleared, EMPTY.
  - TWO: pop -> main<=skid, skid cleared, ONE; no push possible; else hold.
- Order preserved strictly FIFO; skid never overtakes main.
- stall=1 (flush=0): all state held, no push/pop regardless of in_valid/out_ready.
- flush=1: highest priority over stall, push, pop. Next edge: both entries invalid, data 0, ctrl NOP_CTRL, EMPTY. An in_valid offered in the flush cycle is dropped (in_ready still reads per stall/state; the upstream flush logic must squash it too). A pop in the flush cycle still counts as consumed by downstream.
- Cleared entries always hold ctrl=NOP_CTRL so no stale WEN/DWE/HALT can leak.
- occupancy = 0/1/2 registered from state.

Test Plan:
- Reset with in_valid=1, in_data=0xDEAD -> out_valid=0, out_ctrl=NOP_CTRL, occupancy=0; first post-reset push appears one cycle later.
- Streaming: 8 pushes 0x1..0x8, out_ready=1 every cycle -> out_data 0x1..0x8 on consecutive cycles, occupancy stays 1, in_ready never drops.
- Backpressure: out_ready=0, push 0xA,0xB,0xC -> 0xA,0xB accepted, occupancy=2, in_ready=0 holding 0xC; raise out_ready -> out sequence 0xA,0xB,0xC with no loss/duplication.
- Stall: occupancy=2, stall=1 for 3 cycles with out_ready=1, in_valid=1 -> out_valid=0, in_ready=0, contents unchanged; release -> 0xA then 0xB.
- Flush: occupancy=2 with ctrl=0xFF, assert flush together with stall=1 and in_valid=1 -> next cycle occupancy=0, out_ctrl=NOP_CTRL, the offered entry never emerges.
- NOP_CTRL=8'h80 build: reset and after flush out_ctrl=0x80 with out_valid=0.
